ising_sweep_ctrl: RTL

ISING_SWEEP_CTRL -- requirements
Module: ising_sweep_ctrl

---
 rtl/ising_sweep_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ising_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ising_sweep_ctrl
// Description : Zero-temperature sequential spin-update sweep sequencer for an
//               Ising machine (column fetch -> dot product -> spin update).
// Revision    : 1.0  initial release
// ============================================================================
module ising_sweep_ctrl #(
   parameter int VECTOR_WIDTH = 256,
   parameter int N            = 8,
   parameter int ACC_WIDTH    = N + 2*$clog2(VECTOR_WIDTH),
   parameter int SWEEP_W      = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_start,
   input  logic                            i_abort,
   input  logic [SWEEP_W-1:0]              i_num_sweeps,
   input  logic                            i_sigma_load,
   input  logic [VECTOR_WIDTH-1:0]         i_sigma_init,
   output logic                            o_col_req,
   output logic [$clog2(VECTOR_WIDTH)-1:0] o_col_addr,
   input  logic                            i_col_ack,
   output logic                            o_dp_start,
   input  logic                            i_dp_done,
   input  logic signed [ACC_WIDTH:0]       i_dp_result,
   output logic [VECTOR_WIDTH-1:0]         o_sigma,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_converged,
   output logic [SWEEP_W-1:0]              o_sweep_cnt,
   output logic [$clog2(VECTOR_WIDTH):0]   o_flip_cnt
);

   localparam int KW = $clog2(VECTOR_WIDTH);
   localparam int FW = KW + 1;

   localparam logic [KW-1:0]      c_K_ZERO     = '0;
   localparam logic [KW-1:0]      c_K_ONE      = KW'(1);
   localparam logic [KW-1:0]      c_K_LAST     = KW'(VECTOR_WIDTH - 1);
   localparam logic [FW-1:0]      c_FLIP_ZERO  = '0;
   localparam logic [FW-1:0]      c_FLIP_ONE   = FW'(1);
   localparam logic [SWEEP_W-1:0] c_SWEEP_ZERO = '0;
   localparam logic [SWEEP_W-1:0] c_SWEEP_ONE  = SWEEP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DP_RUN    = 3'd2,
      S_UPDATE    = 3'd3,
      S_SWEEP_END = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t                r_state;
   logic [KW-1:0]         r_k;
   logic                  r_h_nonneg;
   logic [SWEEP_W-1:0]    r_max_sweeps;
   logic [VECTOR_WIDTH-1:0] r_sigma;
   logic [SWEEP_W-1:0]    r_sweep_cnt;
   logic [FW-1:0]         r_flip_cnt;
   logic                  r_converged;
   logic                  r_col_req;
   logic [KW-1:0]         r_col_addr;
   logic                  r_dp_start;
   logic                  r_done;
   logic                  r_busy;

   logic                  w_h_nonneg;
   logic [SWEEP_W:0]      w_sweep_next;
   logic                  w_last_sweep;

   // h = 0 is treated as a non-negative field, so the spin settles to +1.
   assign w_h_nonneg   = (i_dp_result >= $signed({(ACC_WIDTH+1){1'b0}}));
   assign w_sweep_next = {1'b0, r_sweep_cnt} + {c_SWEEP_ZERO, 1'b1};
   assign w_last_sweep = (w_sweep_next >= {1'b0, r_max_sweeps});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_k          <= c_K_ZERO;
         r_h_nonneg   <= 1'b0;
         r_max_sweeps <= c_SWEEP_ONE;
         r_sigma      <= '0;
         r_sweep_cnt  <= c_SWEEP_ZERO;
         r_flip_cnt   <= c_FLIP_ZERO;
         r_converged  <= 1'b0;
         r_col_req    <= 1'b0;
         r_col_addr   <= c_K_ZERO;
         r_dp_start   <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else if (i_abort && (r_state != S_IDLE)) begin
         // Partial spin updates are kept; only the handshake state is dropped.
         r_state    <= S_IDLE;
         r_col_req  <= 1'b0;
         r_dp_start <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_dp_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_sigma_load) begin
                  r_sigma <= i_sigma_init;
               end
               if (i_start) begin
                  r_state      <= S_FETCH;
                  r_k          <= c_K_ZERO;
                  r_sweep_cnt  <= c_SWEEP_ZERO;
                  r_flip_cnt   <= c_FLIP_ZERO;
                  r_converged  <= 1'b0;
                  r_max_sweeps <= (i_num_sweeps == c_SWEEP_ZERO) ? c_SWEEP_ONE : i_num_sweeps;
                  r_col_req    <= 1'b1;
                  r_col_addr   <= c_K_ZERO;
                  r_busy       <= 1'b1;
               end
            end

            S_FETCH: begin
               if (i_col_ack) begin
                  r_col_req  <= 1'b0;
                  r_dp_start <= 1'b1;
                  r_state    <= S_DP_RUN;
               end
            end

            S_DP_RUN: begin
               if (i_dp_done) begin
                  r_h_nonneg <= w_h_nonneg;
                  r_state    <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               r_sigma[r_k] <= r_h_nonneg;
               if (r_sigma[r_k] != r_h_nonneg) begin
                  r_flip_cnt <= r_flip_cnt + c_FLIP_ONE;
               end
               if (r_k == c_K_LAST) begin
                  r_state <= S_SWEEP_END;
               end else begin
                  r_k        <= r_k + c_K_ONE;
                  r_col_addr <= r_k + c_K_ONE;
                  r_col_req  <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end

            S_SWEEP_END: begin
               r_sweep_cnt <= w_sweep_next[SWEEP_W-1:0];
               if (r_flip_cnt == c_FLIP_ZERO) begin
                  r_converged <= 1'b1;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end else if (w_last_sweep) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_k        <= c_K_ZERO;
                  r_flip_cnt <= c_FLIP_ZERO;
                  r_col_addr <= c_K_ZERO;
                  r_col_req  <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state   <= S_IDLE;
               r_col_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign o_col_req   = r_col_req;
   assign o_col_addr  = r_col_addr;
   assign o_dp_start  = r_dp_start;
   assign o_sigma     = r_sigma;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_converged = r_converged;
   assign o_sweep_cnt = r_sweep_cnt;
   assign o_flip_cnt  = r_flip_cnt;

endmodule
`default_nettype wire
